instr_encoder: RTL and testbench
================================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, width of the instruction-memory word address; DEPTH = 2**ADDR_WIDTH.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port start  input  1  begins a new load session at word address 0.
REQ-005 SHALL have port in_valid  input  1  encode request valid.
REQ-006 SHALL have port in_ready  output  1  encoder can accept a request.
REQ-007 SHALL have port in_op  input  4  0 add, 1 addi, 2 lbu, 3 sb, 4 lui, 5 bne, 6 bgeu, 7 jalr, 8 jal; 9-15 illegal.
REQ-008 SHALL have ports in_rd, in_rs1, in_rs2  input  5 each  register indices.
REQ-009 SHALL have port in_imm  input  32  signed byte offset; for lui, upper value in bits [31:12].
REQ-010 SHALL have port wr_en  output  1  one-cycle instruction-memory write strobe.
REQ-011 SHALL have port wr_addr  output  ADDR_WIDTH  word address of wr_data.
REQ-012 SHALL have port wr_data  output  32  encoded RV32I instruction word.
REQ-013 SHALL have port count  output  ADDR_WIDTH+1  words written this session.
REQ-014 SHALL have port full  output  1  count == DEPTH.
REQ-015 SHALL have port err  output  1  sticky error flag, cleared only by start or reset.

Function
REQ-016 SHALL implement states IDLE, RUN, FULL; IDLE->RUN on start; RUN->FULL when count reaches DEPTH; any state->RUN on start.
REQ-017 SHALL drive in_ready = (state == RUN) and not start; a request is accepted when in_valid and in_ready are both high at a rising edge.
REQ-018 SHALL register outputs: a request accepted at edge N produces wr_en=1 with wr_addr/wr_data during the cycle after edge N (latency 1); throughput one instruction per cycle.
REQ-019 SHALL deassert wr_en in every cycle not following an accepted legal request.
REQ-020 SHALL encode with fields: add R-type funct3 000 funct7 0; addi/jalr I-type funct3 000; lbu I-type funct3 100; sb S-type funct3 000; lui U-type; bne B-type funct3 001; bgeu B-type funct3 111; jal J-type; opcodes 0110011, 0010011, 0000011, 0100011, 0110111, 1100011, 1100111, 1101111.
REQ-021 SHALL place immediates per RV32I: I imm[11:0], S imm[11:5]/imm[4:0], B imm[12|10:5|4:1|11], U imm[31:12], J imm[20|10:1|11|19:12]; unused register fields SHALL be zero.
REQ-022 SHALL set wr_addr = count[ADDR_WIDTH-1:0] at accept time and increment count by 1 per legal write.
REQ-023 SHALL, on an illegal in_op, accept the request, not write, not advance count, and set err.
REQ-024 SHALL, when full, hold in_ready low and ignore in_valid; count never exceeds DEPTH and wr_addr never wraps within a session.
REQ-025 SHALL, on start, set count to 0 and err to 0, and refuse any request presented in that same cycle; a write already registered from the previous edge still completes.

Reset
REQ-026 SHALL on rst_n low at a rising edge enter IDLE with in_ready=0, wr_en=0, wr_addr=0, wr_data=0, count=0, full=0, err=0.
REQ-027 SHALL let reset override start and any in-flight write; no wr_en in the cycle after a reset edge.

Configuration
REQ-028 SHALL, with IMM_RANGE_CHECK_EN defined, treat out-of-range immediates as REQ-023 errors: I/S outside -2048..2047; B outside -4096..4094 or odd; J outside -1048576..1048574 or odd; lui with imm[11:0] nonzero.
REQ-029 SHALL, without IMM_RANGE_CHECK_EN, silently truncate immediates to the encodable bits, ignore imm[0] for B/J, and never set err from immediate values.

Verification
REQ-030 SHALL cover: start, addi rd=1 rs1=0 imm=5 -> next cycle wr_en=1, wr_addr=0, wr_data=0x00500093, count=1.
REQ-031 SHALL cover: back-to-back add rd=3 rs1=1 rs2=2 then sb rs1=1 rs2=2 imm=3 -> wr_data 0x002081B3 at addr 0 then 0x002081A3 at addr 1 on consecutive cycles.
REQ-032 SHALL cover: bne rs1=1 rs2=0 imm=-8 -> wr_data 0xFE009CE3.
REQ-033 SHALL cover: ADDR_WIDTH=2, four legal requests -> full=1, count=4, in_ready=0; fifth in_valid ignored; start -> count=0, in_ready=1 next cycle.
REQ-034 SHALL cover: in_op=12 -> err=1, no wr_en, count unchanged; start clears err.
REQ-035 SHALL cover: addi rd=1 rs1=0 imm=4096 -> with IMM_RANGE_CHECK_EN err=1 and no write; without it wr_data=0x00000093 and err=0.

Source files
------------

// File: rtl/instr_encoder.sv
// -----------------------------------------------------------------------------
// instr_encoder
//
// Turns a stream of simple instruction requests (opcode selector plus register
// indices and an immediate) into RV32I machine words. It writes them
// sequentially into an instruction memory, starting at word 0 of each load
// session.
//
// Ports
//   clk        sole clock, rising edge
//   rst_n      synchronous active-low reset
//   start      opens a new session: count/err cleared, next write at word 0
//   in_valid   request valid
//   in_ready   request can be taken (session running, not full, no start)
//   in_op      0 add, 1 addi, 2 lbu, 3 sb, 4 lui, 5 bne, 6 bgeu, 7 jalr,
//              8 jal, 9..15 illegal
//   in_rd, in_rs1, in_rs2   register indices
//   in_imm     signed byte offset (lui: upper value in [31:12])
//   wr_en      one-cycle memory write strobe (registered)
//   wr_addr    word address for wr_data
//   wr_data    encoded instruction word
//   count      words written in this session (0..DEPTH)
//   full       count == DEPTH
//   err        sticky: illegal opcode (or bad immediate) seen this session
//
// Build option
//   IMM_RANGE_CHECK_EN  when defined, immediates that do not fit their format
//                       are treated like illegal opcodes. When undefined,
//                       immediates are silently truncated to their encodable
//                       bits.
// -----------------------------------------------------------------------------
module instr_encoder #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            in_op,
  input  logic [4:0]            in_rd,
  input  logic [4:0]            in_rs1,
  input  logic [4:0]            in_rs2,
  input  logic [31:0]           in_imm,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [31:0]           wr_data,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  err
);

  // count value when every word of the memory has been written, and the
  // value one below it (the write that makes the memory full)
  localparam logic [ADDR_WIDTH:0] depth_cnt = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] last_cnt  = {1'b0, {ADDR_WIDTH{1'b1}}};
  localparam logic [ADDR_WIDTH:0] one_cnt   = {{ADDR_WIDTH{1'b0}}, 1'b1};

  // request selectors
  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_ADDI = 4'd1;
  localparam logic [3:0] OP_LBU  = 4'd2;
  localparam logic [3:0] OP_SB   = 4'd3;
  localparam logic [3:0] OP_LUI  = 4'd4;
  localparam logic [3:0] OP_BNE  = 4'd5;
  localparam logic [3:0] OP_BGEU = 4'd6;
  localparam logic [3:0] OP_JALR = 4'd7;
  localparam logic [3:0] OP_JAL  = 4'd8;

  // RV32I major opcodes
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FULL = 2'd2
  } state_t;

  state_t state_reg;
  state_t state_next;

  // ---------------------------------------------------------------------------
  // Instruction format builders
  // ---------------------------------------------------------------------------
  function automatic logic [31:0] enc_r(
    input logic [6:0] funct7,
    input logic [4:0] rs2,
    input logic [4:0] rs1,
    input logic [2:0] funct3,
    input logic [4:0] rd,
    input logic [6:0] opc
  );
    return {funct7, rs2, rs1, funct3, rd, opc};
  endfunction

  function automatic logic [31:0] enc_i(
    input logic [11:0] imm,
    input logic [4:0]  rs1,
    input logic [2:0]  funct3,
    input logic [4:0]  rd,
    input logic [6:0]  opc
  );
    return {imm, rs1, funct3, rd, opc};
  endfunction

  function automatic logic [31:0] enc_s(
    input logic [11:0] imm,
    input logic [4:0]  rs2,
    input logic [4:0]  rs1,
    input logic [2:0]  funct3,
    input logic [6:0]  opc
  );
    return {imm[11:5], rs2, rs1, funct3, imm[4:0], opc};
  endfunction

  // branch offsets are always even; bit 0 is not part of the encoding
  function automatic logic [31:0] enc_b(
    input logic [12:1] imm,
    input logic [4:0]  rs2,
    input logic [4:0]  rs1,
    input logic [2:0]  funct3,
    input logic [6:0]  opc
  );
    return {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opc};
  endfunction

  function automatic logic [31:0] enc_u(
    input logic [31:12] imm,
    input logic [4:0]   rd,
    input logic [6:0]   opc
  );
    return {imm, rd, opc};
  endfunction

  function automatic logic [31:0] enc_j(
    input logic [20:1] imm,
    input logic [4:0]  rd,
    input logic [6:0]  opc
  );
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, opc};
  endfunction

  // ---------------------------------------------------------------------------
  // Immediate range qualification
  // ---------------------------------------------------------------------------
  logic fit_i;   // I/S: -2048..2047
  logic fit_b;   // B:   -4096..4094, even
  logic fit_j;   // J:   -1048576..1048574, even
  logic fit_u;   // U:   low 12 bits must be zero

`ifdef IMM_RANGE_CHECK_EN
  // A value fits an N-bit signed field when every bit above the field's
  // sign bit is a copy of it, i.e. the upper slice is all zeros or all ones.
  assign fit_i = (&in_imm[31:11]) | ~(|in_imm[31:11]);
  assign fit_b = ((&in_imm[31:12]) | ~(|in_imm[31:12])) & ~in_imm[0];
  assign fit_j = ((&in_imm[31:20]) | ~(|in_imm[31:20])) & ~in_imm[0];
  assign fit_u = ~(|in_imm[11:0]);
`else
  assign fit_i = 1'b1;
  assign fit_b = 1'b1;
  assign fit_j = 1'b1;
  assign fit_u = 1'b1;
`endif

  // ---------------------------------------------------------------------------
  // Combinational encode of the presented request
  // ---------------------------------------------------------------------------
  logic [31:0] enc_word;
  logic        op_legal;
  logic        imm_ok;

  always_comb begin
    enc_word = '0;
    op_legal = 1'b1;
    imm_ok   = 1'b1;
    case (in_op)
      OP_ADD: begin
        enc_word = enc_r(7'b0000000, in_rs2, in_rs1, 3'b000, in_rd, OPC_OP);
      end
      OP_ADDI: begin
        enc_word = enc_i(in_imm[11:0], in_rs1, 3'b000, in_rd, OPC_OPIMM);
        imm_ok   = fit_i;
      end
      OP_LBU: begin
        enc_word = enc_i(in_imm[11:0], in_rs1, 3'b100, in_rd, OPC_LOAD);
        imm_ok   = fit_i;
      end
      OP_SB: begin
        enc_word = enc_s(in_imm[11:0], in_rs2, in_rs1, 3'b000, OPC_STORE);
        imm_ok   = fit_i;
      end
      OP_LUI: begin
        enc_word = enc_u(in_imm[31:12], in_rd, OPC_LUI);
        imm_ok   = fit_u;
      end
      OP_BNE: begin
        enc_word = enc_b(in_imm[12:1], in_rs2, in_rs1, 3'b001, OPC_BRANCH);
        imm_ok   = fit_b;
      end
      OP_BGEU: begin
        enc_word = enc_b(in_imm[12:1], in_rs2, in_rs1, 3'b111, OPC_BRANCH);
        imm_ok   = fit_b;
      end
      OP_JALR: begin
        enc_word = enc_i(in_imm[11:0], in_rs1, 3'b000, in_rd, OPC_JALR);
        imm_ok   = fit_i;
      end
      OP_JAL: begin
        enc_word = enc_j(in_imm[20:1], in_rd, OPC_JAL);
        imm_ok   = fit_j;
      end
      default: begin
        op_legal = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  logic accept;
  logic write_fire;
  logic bad_req;

  // start takes priority over any request presented in the same cycle
  assign in_ready   = (state_reg == RUN) && !start;
  assign accept     = in_valid && in_ready;
  assign write_fire = accept && op_legal && imm_ok;
  // bad requests are consumed (handshake completes) but leave no trace in memory
  assign bad_req    = accept && !(op_legal && imm_ok);

  // ---------------------------------------------------------------------------
  // Session state machine
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        state_next = IDLE;
      end
      RUN: begin
        // the write that takes count to DEPTH closes the session
        if (write_fire && (count == last_cnt)) begin
          state_next = FULL;
        end
      end
      FULL: begin
        state_next = FULL;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    if (start) begin
      state_next = RUN;
    end
  end

  // ---------------------------------------------------------------------------
  // Registered write port, word counter and sticky error
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      count   <= '0;
      err     <= 1'b0;
    end else begin
      wr_en <= write_fire;
      if (start) begin
        count <= '0;
        err   <= 1'b0;
      end else begin
        if (write_fire) begin
          wr_addr <= count[ADDR_WIDTH-1:0];
          wr_data <= enc_word;
          count   <= count + one_cnt;
        end
        if (bad_req) begin
          err <= 1'b1;
        end
      end
    end
  end

  assign full = (count == depth_cnt);

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;

  localparam int AW     = 10;
  localparam int DEPTH  = 1 << AW;
  localparam int SAW    = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         start;
  logic         in_valid;
  logic [3:0]   in_op;
  logic [4:0]   in_rd, in_rs1, in_rs2;
  logic [31:0]  in_imm;

  logic         in_ready, wr_en, full, err;
  logic [AW-1:0] wr_addr;
  logic [31:0]  wr_data;
  logic [AW:0]  count;

  logic          s_in_ready, s_wr_en, s_full, s_err;
  logic [SAW-1:0] s_wr_addr;
  logic [31:0]   s_wr_data;
  logic [SAW:0]  s_count;

  instr_encoder #(.ADDR_WIDTH(AW)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .in_ready(in_ready), .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1),
    .in_rs2(in_rs2), .in_imm(in_imm), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .count(count), .full(full), .err(err)
  );

  instr_encoder #(.ADDR_WIDTH(SAW)) u_small (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .in_ready(s_in_ready), .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1),
    .in_rs2(in_rs2), .in_imm(in_imm), .wr_en(s_wr_en), .wr_addr(s_wr_addr),
    .wr_data(s_wr_data), .count(s_count), .full(s_full), .err(s_err)
  );

  int checks = 0;
  int errors = 0;
  int txn    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: session bookkeeping plus RV32I field placement done with
  // shifts and masks on the immediate value.
  // ---------------------------------------------------------------------------
  bit          m_active;
  int          m_count;
  bit          m_err;
  bit          m_wr_en;
  int          m_addr;
  logic [31:0] m_data;

  function automatic logic [31:0] fld(input logic [31:0] v, input int hi, input int lo);
    return (v >> lo) & ((32'd1 << (hi - lo + 1)) - 32'd1);
  endfunction

  function automatic logic [31:0] model_enc(input int op, input int rd, input int rs1,
                                            input int rs2, input logic [31:0] imm);
    logic [31:0] d, s1, s2, w;
    d  = 32'(rd);
    s1 = 32'(rs1);
    s2 = 32'(rs2);
    w  = 32'd0;
    case (op)
      0: w = 32'h33 + (d << 7) + (s1 << 15) + (s2 << 20);
      1: w = 32'h13 + (d << 7) + (s1 << 15) + (fld(imm, 11, 0) << 20);
      2: w = 32'h03 + (d << 7) + (32'd4 << 12) + (s1 << 15) + (fld(imm, 11, 0) << 20);
      3: w = 32'h23 + (fld(imm, 4, 0) << 7) + (s1 << 15) + (s2 << 20) + (fld(imm, 11, 5) << 25);
      4: w = 32'h37 + (d << 7) + (imm & 32'hFFFFF000);
      5, 6: w = 32'h63 + (fld(imm, 11, 11) << 7) + (fld(imm, 4, 1) << 8)
                + ((op == 5 ? 32'd1 : 32'd7) << 12) + (s1 << 15) + (s2 << 20)
                + (fld(imm, 10, 5) << 25) + (fld(imm, 12, 12) << 31);
      7: w = 32'h67 + (d << 7) + (s1 << 15) + (fld(imm, 11, 0) << 20);
      8: w = 32'h6F + (d << 7) + (fld(imm, 19, 12) << 12) + (fld(imm, 11, 11) << 20)
             + (fld(imm, 10, 1) << 21) + (fld(imm, 20, 20) << 31);
      default: w = 32'd0;
    endcase
    return w;
  endfunction

  function automatic bit model_legal(input int op, input logic [31:0] imm);
    bit ok;
    longint s;
    s  = longint'($signed(imm));
    ok = (op <= 8);
`ifdef IMM_RANGE_CHECK_EN
    case (op)
      1, 2, 3, 7: ok = (s >= -2048) && (s <= 2047);
      5, 6:       ok = (s >= -4096) && (s <= 4094) && (s % 2 == 0);
      8:          ok = (s >= -1048576) && (s <= 1048574) && (s % 2 == 0);
      4:          ok = ((imm & 32'hFFF) == 32'd0);
      default:    ;
    endcase
`else
    if (s == 0) ok = ok;
`endif
    return ok;
  endfunction

  // One clock of stimulus: drive at the falling edge, check in_ready against
  // the model, advance the model across the rising edge, check all outputs at
  // the next falling edge.
  task automatic cycle(input bit st, input bit v, input int op, input int rd,
                       input int rs1, input int rs2, input logic [31:0] imm);
    bit exp_ready;
    start    = st;
    in_valid = v;
    in_op    = 4'(op);
    in_rd    = 5'(rd);
    in_rs1   = 5'(rs1);
    in_rs2   = 5'(rs2);
    in_imm   = imm;
    #1;
    exp_ready = m_active && (m_count < DEPTH) && !st;
    chk("in_ready", 32'(in_ready), 32'(exp_ready));
    if (st) begin
      m_active = 1'b1;
      m_count  = 0;
      m_err    = 1'b0;
      m_wr_en  = 1'b0;
    end else if (v && exp_ready) begin
      if (model_legal(op, imm)) begin
        m_wr_en = 1'b1;
        m_addr  = m_count;
        m_data  = model_enc(op, rd, rs1, rs2, imm);
        m_count++;
      end else begin
        m_wr_en = 1'b0;
        m_err   = 1'b1;
      end
    end else begin
      m_wr_en = 1'b0;
    end
    @(negedge clk);
    txn++;
    $display("txn %0d: start=%0b valid=%0b op=%0d imm=%08h -> wr_en=%0b addr=%0d data=%08h count=%0d full=%0b err=%0b",
             txn, st, v, op, imm, wr_en, wr_addr, wr_data, count, full, err);
    chk("wr_en", 32'(wr_en), 32'(m_wr_en));
    if (m_wr_en) begin
      chk("wr_addr", 32'(wr_addr), 32'(m_addr));
      chk("wr_data", wr_data, m_data);
    end
    chk("count", 32'(count), 32'(m_count));
    chk("full", 32'(full), 32'(m_count == DEPTH));
    chk("err", 32'(err), 32'(m_err));
  endtask

  // Reset edge, optionally with start and a legal request also presented,
  // to show that reset wins.
  task automatic do_reset(input bit st);
    rst_n    = 1'b0;
    start    = st;
    in_valid = 1'b1;
    in_op    = 4'd1;
    in_rd    = 5'd1;
    in_rs1   = 5'd0;
    in_rs2   = 5'd0;
    in_imm   = 32'd5;
    @(negedge clk);
    txn++;
    $display("txn %0d: reset start=%0b -> wr_en=%0b count=%0d err=%0b", txn, st, wr_en, count, err);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_wr_data", wr_data, 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst_n    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    m_active = 1'b0;
    m_count  = 0;
    m_err    = 1'b0;
    m_wr_en  = 1'b0;
  endtask

  typedef struct {
    bit          restart;
    int          op;
    int          rd;
    int          rs1;
    int          rs2;
    logic [31:0] imm;
    logic [31:0] exp_data;
    int          exp_addr;
    bit          rng_bad;
    string       name;
  } vec_t;

  vec_t tbl[11];

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int pick;
    int op;
    logic [31:0] imm;
    logic [31:0] edge_imm [12];

    tbl[0]  = '{1'b1, 1, 1, 0, 0, 32'd5,        32'h00500093, 0, 1'b0, "addi_x1_5"};
    tbl[1]  = '{1'b1, 0, 3, 1, 2, 32'd0,        32'h002081B3, 0, 1'b0, "add_x3"};
    tbl[2]  = '{1'b0, 3, 0, 1, 2, 32'd3,        32'h002081A3, 1, 1'b0, "sb_3"};
    tbl[3]  = '{1'b0, 5, 0, 1, 0, 32'hFFFFFFF8, 32'hFE009CE3, 2, 1'b0, "bne_m8"};
    tbl[4]  = '{1'b0, 4, 5, 0, 0, 32'h12345000, 32'h123452B7, 3, 1'b0, "lui"};
    tbl[5]  = '{1'b0, 2, 2, 3, 0, 32'hFFFFFFFF, 32'hFFF1C103, 4, 1'b0, "lbu_m1"};
    tbl[6]  = '{1'b0, 6, 0, 4, 5, 32'd16,       32'h00527863, 5, 1'b0, "bgeu_16"};
    tbl[7]  = '{1'b0, 7, 1, 6, 0, 32'd16,       32'h010300E7, 6, 1'b0, "jalr_16"};
    tbl[8]  = '{1'b0, 8, 1, 0, 0, 32'd2048,     32'h001000EF, 7, 1'b0, "jal_2048"};
    tbl[9]  = '{1'b0, 8, 0, 0, 0, 32'hFFFFFFFE, 32'hFFFFF06F, 8, 1'b0, "jal_m2"};
    tbl[10] = '{1'b0, 1, 1, 0, 0, 32'd4096,     32'h00000093, 9, 1'b1, "addi_4096"};

    edge_imm[0]  = 32'd2047;      edge_imm[1]  = 32'hFFFFF800;  // -2048
    edge_imm[2]  = 32'd2048;      edge_imm[3]  = 32'hFFFFF7FF;  // -2049
    edge_imm[4]  = 32'd4094;      edge_imm[5]  = 32'd4095;
    edge_imm[6]  = 32'hFFFFF000;  edge_imm[7]  = 32'hFFFFEFFE;  // -4096, -4098
    edge_imm[8]  = 32'd1048574;   edge_imm[9]  = 32'hFFF00000;  // -1048576
    edge_imm[10] = 32'd1048576;   edge_imm[11] = 32'h12345000;

    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_op = '0;
    in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
    @(negedge clk);
    do_reset(1'b0);

    // idle: requests are not taken before the first start
    cycle(0, 1, 1, 1, 0, 0, 32'd5);

    // directed encodings
    for (int i = 0; i < 11; i++) begin
      if (tbl[i].restart) cycle(1, 0, 0, 0, 0, 0, 32'd0);
      cycle(0, 1, tbl[i].op, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, tbl[i].imm);
`ifdef IMM_RANGE_CHECK_EN
      if (tbl[i].rng_bad) begin
        chk({tbl[i].name, "_err"}, 32'(err), 32'd1);
        chk({tbl[i].name, "_no_wr"}, 32'(wr_en), 32'd0);
      end else begin
        chk(tbl[i].name, wr_data, tbl[i].exp_data);
        chk({tbl[i].name, "_addr"}, 32'(wr_addr), 32'(tbl[i].exp_addr));
      end
`else
      chk(tbl[i].name, wr_data, tbl[i].exp_data);
      chk({tbl[i].name, "_addr"}, 32'(wr_addr), 32'(tbl[i].exp_addr));
      chk({tbl[i].name, "_err"}, 32'(err), 32'd0);
`endif
    end

    // illegal opcode: consumed, not written, count held, err sticky until start
    cycle(1, 0, 0, 0, 0, 0, 32'd0);
    cycle(0, 1, 1, 2, 0, 0, 32'd7);
    cycle(0, 1, 12, 2, 0, 0, 32'd7);
    chk("illegal_err", 32'(err), 32'd1);
    chk("illegal_count", 32'(count), 32'd1);
    chk("illegal_no_wr", 32'(wr_en), 32'd0);
    cycle(0, 0, 0, 0, 0, 0, 32'd0);
    chk("err_sticky", 32'(err), 32'd1);
    cycle(1, 1, 1, 2, 0, 0, 32'd7);
    chk("start_clears_err", 32'(err), 32'd0);

    // small instance: fill, refuse the fifth request, restart
    cycle(1, 0, 0, 0, 0, 0, 32'd0);
    for (int k = 0; k < 4; k++) begin
      cycle(0, 1, 1, k + 1, 0, 0, 32'(k));
      chk("small_wr_en", 32'(s_wr_en), 32'd1);
      chk("small_wr_addr", 32'(s_wr_addr), 32'(k));
      chk("small_count", 32'(s_count), 32'(k + 1));
    end
    chk("small_full", 32'(s_full), 32'd1);
    chk("small_in_ready_full", 32'(s_in_ready), 32'd0);
    cycle(0, 1, 1, 9, 0, 0, 32'd1);
    chk("small_5th_no_wr", 32'(s_wr_en), 32'd0);
    chk("small_5th_count", 32'(s_count), 32'd4);
    cycle(1, 1, 1, 9, 0, 0, 32'd1);
    chk("small_restart_count", 32'(s_count), 32'd0);
    chk("small_restart_full", 32'(s_full), 32'd0);
    start = 1'b0;
    #1;
    chk("small_restart_ready", 32'(s_in_ready), 32'd1);

    // reset overrides start and a legal request
    cycle(0, 1, 0, 1, 2, 3, 32'd0);
    do_reset(1'b1);
    cycle(0, 0, 0, 0, 0, 0, 32'd0);

    // randomized traffic against the model
    cycle(1, 0, 0, 0, 0, 0, 32'd0);
    for (int n = 0; n < 600; n++) begin
      op = ($urandom_range(0, 9) == 0) ? int'($urandom_range(9, 15)) : int'($urandom_range(0, 8));
      pick = int'($urandom_range(0, 3));
      if (pick == 0)      imm = $urandom;
      else if (pick == 1) imm = edge_imm[$urandom_range(0, 11)];
      else                imm = 32'($urandom_range(0, 8191)) - 32'd4096;
      cycle(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) < 7), op,
            int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
            int'($urandom_range(0, 31)), imm);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
